alu_op_sequencer: RTL and testbench

//  Multi-cycle control sequencer for the CPU datapath's register/immediate ALU instructions.

---
 rtl/alu_op_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Multi-cycle control sequencer for the register/immediate ALU instructions.
// It accepts one instruction word per valid/ready handshake. It then steps the
// datapath through operand load, ALU execute, write-back capture and
// register-file write, spending one state per clock.
//
// Ports
//   iClk, iRst            clock (rising edge), asynchronous active-high reset
//   iIns, iIns_valid      instruction word op[31:27] ra[26:23] rb[22:19]
//                         rc[18:15] C[18:0], and its valid flag
//   oIns_ready            idle and not stalled, so an instruction can be taken
//   iHold                 stall: freeze the sequence and drop every strobe
//   oRF_AddrA/B/C         register-file read A (rb), read B (rc), write (ra)
//   oRF_Write             register-file write strobe
//   oRA_en .. oRWB_en     datapath register enables
//   oALU_Ctrl             ALU operation (low four opcode bits)
//   oMUX_BIS              ALU B select: 1 = oImm32, 0 = RB
//   oMUX_RZHS/WBM/WBP/ASS fixed datapath selects, always 0
//   oImm32                sign-extended C for I-class, else 0
//   oDone, oIllegal       one-cycle pulses: instruction retired / rejected
module alu_op_sequencer #(
    parameter int IMM_W = 19
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] iIns,
    input  logic        iIns_valid,
    output logic        oIns_ready,
    input  logic        iHold,
    output logic [3:0]  oRF_AddrA,
    output logic [3:0]  oRF_AddrB,
    output logic [3:0]  oRF_AddrC,
    output logic        oRF_Write,
    output logic        oRA_en,
    output logic        oRB_en,
    output logic        oRZH_en,
    output logic        oRZL_en,
    output logic        oRWB_en,
    output logic [3:0]  oALU_Ctrl,
    output logic        oMUX_BIS,
    output logic        oMUX_RZHS,
    output logic        oMUX_WBM,
    output logic        oMUX_WBP,
    output logic        oMUX_ASS,
    output logic [31:0] oImm32,
    output logic        oDone,
    output logic        oIllegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDA,
        S_LDB,
        S_EXEC,
        S_WB,
        S_RFW
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  op_q;
    logic [3:0]  ra_q;
    logic [3:0]  rb_q;
    logic [3:0]  rc_q;

    logic [4:0]  op_in;
    logic        in_r;
    logic        in_i;
    logic        in_u;
    logic        in_legal;
    logic        q_r;
    logic        q_i;
    logic        accept;
    logic [31:0] imm_in;

    // Opcode classes: R = 3..11, I = 12..14, U = 17 and 18.
    assign op_in    = iIns[31:27];
    assign in_r     = (op_in >= 5'd3) && (op_in <= 5'd11);
    assign in_i     = (op_in >= 5'd12) && (op_in <= 5'd14);
    assign in_u     = (op_in == 5'd17) || (op_in == 5'd18);
    assign in_legal = in_r || in_i || in_u;

    assign q_r = (op_q >= 5'd3) && (op_q <= 5'd11);
    assign q_i = (op_q >= 5'd12) && (op_q <= 5'd14);

    assign imm_in = {{(32-IMM_W){iIns[IMM_W-1]}}, iIns[IMM_W-1:0]};

    // Ready is combinational, so a stall seen in IDLE blocks the handshake in the same cycle.
    assign oIns_ready = (state == S_IDLE) && !iHold;
    assign accept     = iIns_valid && oIns_ready;

    assign oMUX_RZHS = 1'b0;
    assign oMUX_WBM  = 1'b0;
    assign oMUX_WBP  = 1'b0;
    assign oMUX_ASS  = 1'b0;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A hold freezes the current step, so that step runs exactly once after release.
    always_comb begin
        state_next = state;
        if (!iHold) begin
            case (state)
                S_IDLE: if (accept && in_legal) state_next = S_LDA;
                S_LDA:  state_next = q_r ? S_LDB : S_EXEC;
                S_LDB:  state_next = S_EXEC;
                S_EXEC: state_next = S_WB;
                S_WB:   state_next = S_RFW;
                S_RFW:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Fields are latched on every accept, illegal ones included, and then held until the next accept.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            op_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
            rc_q <= '0;
        end else if (accept) begin
            op_q <= iIns[31:27];
            ra_q <= iIns[26:23];
            rb_q <= iIns[22:19];
            rc_q <= iIns[18:15];
        end
    end

    // The outputs are registered from the current state. Each strobe therefore
    // appears the cycle after its state is entered. Addresses and ALU_Ctrl keep
    // their last value.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oRA_en    <= 1'b0;
            oRB_en    <= 1'b0;
            oRZH_en   <= 1'b0;
            oRZL_en   <= 1'b0;
            oRWB_en   <= 1'b0;
            oRF_Write <= 1'b0;
            oDone     <= 1'b0;
            oIllegal  <= 1'b0;
            oMUX_BIS  <= 1'b0;
            oRF_AddrA <= '0;
            oRF_AddrB <= '0;
            oRF_AddrC <= '0;
            oALU_Ctrl <= '0;
            oImm32    <= '0;
        end else begin
            oRA_en    <= !iHold && (state == S_LDA);
            oRB_en    <= !iHold && (state == S_LDB);
            oRZH_en   <= !iHold && (state == S_EXEC);
            oRZL_en   <= !iHold && (state == S_EXEC);
            oRWB_en   <= !iHold && (state == S_WB);
            oRF_Write <= !iHold && (state == S_RFW);
            oDone     <= !iHold && (state == S_RFW);
            oIllegal  <= accept && !in_legal;
            oMUX_BIS  <= !iHold && (state == S_EXEC) && q_i;
            if (!iHold) begin
                case (state)
                    S_LDA:  oRF_AddrA <= rb_q;
                    S_LDB:  oRF_AddrB <= rc_q;
                    S_EXEC: oALU_Ctrl <= op_q[3:0];
                    S_RFW:  oRF_AddrC <= ra_q;
                    default: ;
                endcase
            end
            if (accept) begin
                oImm32 <= in_i ? imm_in : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//
// Bench for alu_op_sequencer. A small datapath (register file, operand,
// result and write-back registers) follows the sequencer's strobes. A queue
// model predicts, for every cycle, the strobes, addresses, immediate and ready
// that the sequencer should present.
// Ports: none (top-level bench).
module tb_alu_op_sequencer;

    localparam int IMM_W = 19;
    localparam int STEP_LDA  = 0;
    localparam int STEP_LDB  = 1;
    localparam int STEP_EXEC = 2;
    localparam int STEP_WB   = 3;
    localparam int STEP_RFW  = 4;
    localparam logic [4:0] LEGAL_OPS [14] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                              5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd17, 5'd18};

    logic        iClk;
    logic        iRst;
    logic [31:0] iIns;
    logic        iIns_valid;
    logic        oIns_ready;
    logic        iHold;
    logic [3:0]  oRF_AddrA;
    logic [3:0]  oRF_AddrB;
    logic [3:0]  oRF_AddrC;
    logic        oRF_Write;
    logic        oRA_en;
    logic        oRB_en;
    logic        oRZH_en;
    logic        oRZL_en;
    logic        oRWB_en;
    logic [3:0]  oALU_Ctrl;
    logic        oMUX_BIS;
    logic        oMUX_RZHS;
    logic        oMUX_WBM;
    logic        oMUX_WBP;
    logic        oMUX_ASS;
    logic [31:0] oImm32;
    logic        oDone;
    logic        oIllegal;

    alu_op_sequencer #(.IMM_W(IMM_W)) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iIns       (iIns),
        .iIns_valid (iIns_valid),
        .oIns_ready (oIns_ready),
        .iHold      (iHold),
        .oRF_AddrA  (oRF_AddrA),
        .oRF_AddrB  (oRF_AddrB),
        .oRF_AddrC  (oRF_AddrC),
        .oRF_Write  (oRF_Write),
        .oRA_en     (oRA_en),
        .oRB_en     (oRB_en),
        .oRZH_en    (oRZH_en),
        .oRZL_en    (oRZL_en),
        .oRWB_en    (oRWB_en),
        .oALU_Ctrl  (oALU_Ctrl),
        .oMUX_BIS   (oMUX_BIS),
        .oMUX_RZHS  (oMUX_RZHS),
        .oMUX_WBM   (oMUX_WBM),
        .oMUX_WBP   (oMUX_WBP),
        .oMUX_ASS   (oMUX_ASS),
        .oImm32     (oImm32),
        .oDone      (oDone),
        .oIllegal   (oIllegal)
    );

    always #5 iClk = ~iClk;

    int checks;
    int errors;
    int cycle;

    logic        loadRf;
    logic [31:0] rf [16];
    logic [31:0] expRf [16];
    logic [31:0] dpA;
    logic [31:0] dpB;
    logic [31:0] dpZ;
    logic [31:0] dpWB;

    int          stepQ [$];
    logic [4:0]  mdlOp;
    logic [3:0]  mdlRa;
    logic [3:0]  mdlRb;
    logic [3:0]  mdlRc;
    logic [31:0] mdlResult;
    logic [7:0]  expStrobes;
    logic        expBis;
    logic [3:0]  expAddrA;
    logic [3:0]  expAddrB;
    logic [3:0]  expAddrC;
    logic [3:0]  expAlu;
    logic [31:0] expImm;
    int          acceptEdge;
    int          doneEdge;
    logic        doneSeen;
    logic        rbSeen;

    // Architectural meaning of each opcode.
    function automatic logic [31:0] aluFn(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned s;
        s = int'(b[4:0]);
        case (op)
            5'd3:  return a + b;
            5'd4:  return a - b;
            5'd5:  return a & b;
            5'd6:  return a | b;
            5'd7:  return a >> s;
            5'd8:  return $signed(a) >>> s;
            5'd9:  return a << s;
            5'd10: return (a >> s) | (a << (32 - s));
            5'd11: return (a << s) | (a >> (32 - s));
            5'd12: return a + b;
            5'd13: return a & b;
            5'd14: return a | b;
            5'd17: return 32'd0 - a;
            5'd18: return ~a;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic isRClass(input logic [4:0] op);
        return (op >= 5'd3) && (op <= 5'd11);
    endfunction

    function automatic logic isIClass(input logic [4:0] op);
        return (op >= 5'd12) && (op <= 5'd14);
    endfunction

    function automatic logic isLegal(input logic [4:0] op);
        return isRClass(op) || isIClass(op) || (op == 5'd17) || (op == 5'd18);
    endfunction

    // The datapath driven by the sequencer. The ALU control code is mapped back
    // to an opcode (ops 17/18 have low nibble 1/2).
    always @(posedge iClk) begin
        if (loadRf) begin
            for (int i = 0; i < 16; i++) rf[i] <= expRf[i];
        end else begin
            if (oRA_en) dpA <= rf[oRF_AddrA];
            if (oRB_en) dpB <= rf[oRF_AddrB];
            if (oRZL_en) dpZ <= aluFn({(oALU_Ctrl == 4'd1) || (oALU_Ctrl == 4'd2), oALU_Ctrl},
                                      dpA, oMUX_BIS ? oImm32 : dpB);
            if (oRWB_en) dpWB <= dpZ;
            if (oRF_Write) rf[oRF_AddrC] <= dpWB;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h cycle=%0d",
                     tag, observed, expected, cycle);
        end
    endtask

    // Compare everything the sequencer presents in this cycle against the model.
    task automatic checkCycle();
        logic [7:0] strobes;
        strobes = {oRA_en, oRB_en, oRZH_en, oRZL_en, oRWB_en, oRF_Write, oDone, oIllegal};
        checkOutput("strobes", 32'(strobes), 32'(expStrobes));
        checkOutput("onehot", 32'($countones({oRA_en, oRB_en, oRZL_en, oRWB_en, oRF_Write}) > 1), 32'd0);
        checkOutput("bis", 32'(oMUX_BIS), 32'(expBis));
        checkOutput("addrA", 32'(oRF_AddrA), 32'(expAddrA));
        checkOutput("addrB", 32'(oRF_AddrB), 32'(expAddrB));
        checkOutput("addrC", 32'(oRF_AddrC), 32'(expAddrC));
        checkOutput("aluCtrl", 32'(oALU_Ctrl), 32'(expAlu));
        checkOutput("imm32", oImm32, expImm);
        checkOutput("ready", 32'(oIns_ready), 32'((stepQ.size() == 0) && !iHold));
        checkOutput("muxFixed", {28'd0, oMUX_RZHS, oMUX_WBM, oMUX_WBP, oMUX_ASS}, 32'd0);
        if (oDone) begin
            doneSeen = 1'b1;
            doneEdge = cycle;
        end
        if (oRB_en) rbSeen = 1'b1;
    endtask

    // Called at a falling edge: check this cycle, drive the next inputs, then
    // predict what the following rising edge should produce.
    task automatic applyStimulus(input logic valid, input logic [31:0] ins, input logic hold);
        int step;
        checkCycle();
        iIns_valid = valid;
        iIns       = ins;
        iHold      = hold;
        expStrobes = '0;
        expBis     = 1'b0;
        if (stepQ.size() != 0) begin
            if (!hold) begin
                step = stepQ.pop_front();
                case (step)
                    STEP_LDA: begin expStrobes[7] = 1'b1; expAddrA = mdlRb; end
                    STEP_LDB: begin expStrobes[6] = 1'b1; expAddrB = mdlRc; end
                    STEP_EXEC: begin
                        expStrobes[5:4] = 2'b11;
                        expAlu = mdlOp[3:0];
                        expBis = isIClass(mdlOp);
                    end
                    STEP_WB: expStrobes[3] = 1'b1;
                    default: begin
                        expStrobes[2:1] = 2'b11;
                        expAddrC = mdlRa;
                        expRf[mdlRa] = mdlResult;
                    end
                endcase
            end
        end else if (valid && !hold) begin
            acceptEdge = cycle + 1;
            mdlOp = ins[31:27];
            mdlRa = ins[26:23];
            mdlRb = ins[22:19];
            mdlRc = ins[18:15];
            expImm = isIClass(mdlOp) ? {{(32-IMM_W){ins[IMM_W-1]}}, ins[IMM_W-1:0]} : 32'd0;
            if (isLegal(mdlOp)) begin
                stepQ.push_back(STEP_LDA);
                if (isRClass(mdlOp)) stepQ.push_back(STEP_LDB);
                stepQ.push_back(STEP_EXEC);
                stepQ.push_back(STEP_WB);
                stepQ.push_back(STEP_RFW);
                mdlResult = aluFn(mdlOp, expRf[mdlRb], isIClass(mdlOp) ? expImm : expRf[mdlRc]);
            end else begin
                expStrobes[0] = 1'b1;
            end
        end
        @(negedge iClk);
        cycle++;
    endtask

    // Assert reset mid-cycle and check that the outputs clear without waiting for a clock edge.
    task automatic applyReset();
        iRst       = 1'b1;
        iHold      = 1'b0;
        iIns_valid = 1'b0;
        #1;
        stepQ.delete();
        expStrobes = '0;
        expBis     = 1'b0;
        expAddrA   = '0;
        expAddrB   = '0;
        expAddrC   = '0;
        expAlu     = '0;
        expImm     = '0;
        checkCycle();
        @(negedge iClk);
        cycle++;
        iRst = 1'b0;
    endtask

    // Issue one instruction, optionally stalling offsets holdAt..holdAt+holdLen-1.
    task automatic runOne(input string name, input logic [31:0] ins, input int holdAt,
                          input int holdLen, input int expLat);
        doneSeen = 1'b0;
        applyStimulus(1'b1, ins, 1'b0);
        for (int i = 1; i <= 30 && !doneSeen; i++)
            applyStimulus(1'b0, 32'd0, (i >= holdAt) && (i < holdAt + holdLen));
        checkOutput({name, "_done"}, 32'(doneSeen), 32'd1);
        if (doneSeen) checkOutput({name, "_latency"}, doneEdge - acceptEdge, expLat);
        applyStimulus(1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [4:0] op;
        checks = 0;
        errors = 0;
        cycle = 0;
        iClk = 1'b0;
        iRst = 1'b1;
        iIns = '0;
        iIns_valid = 1'b0;
        iHold = 1'b0;
        loadRf = 1'b1;
        rbSeen = 1'b0;
        doneSeen = 1'b0;
        for (int i = 0; i < 16; i++) expRf[i] = 32'h1000_0000 + 32'(i * 32'h0101);
        expRf[1] = 32'd5;
        expRf[2] = 32'd7;
        expRf[5] = 32'h22;
        expRf[7] = 32'hA5A5_A5A5;
        @(negedge iClk);
        applyReset();
        loadRf = 1'b0;

        runOne("add", {5'd3, 4'd3, 4'd1, 4'd2, 15'd0}, 0, 0, 5);
        checkOutput("add_r3", rf[3], 32'd12);

        runOne("addi", {5'd12, 4'd4, 4'd5, 19'h7FFFD}, 0, 0, 4);
        checkOutput("addi_imm", oImm32, 32'hFFFF_FFFD);
        checkOutput("addi_r4", rf[4], 32'h1F);

        rbSeen = 1'b0;
        runOne("neg", {5'd17, 4'd5, 4'd5, 19'd0}, 0, 0, 4);
        checkOutput("neg_r5", rf[5], 32'hFFFF_FFDE);
        checkOutput("neg_noRB", 32'(rbSeen), 32'd0);

        applyStimulus(1'b1, {5'd31, 27'h123_4567}, 1'b0);
        checkOutput("illegal_pulse", 32'(oIllegal), 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b0);
        checkOutput("illegal_once", 32'(oIllegal), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b0);

        runOne("hold", {5'd3, 4'd6, 4'd1, 4'd2, 15'd0}, 3, 3, 8);
        checkOutput("hold_r6", rf[6], 32'd12);

        applyStimulus(1'b1, {5'd3, 4'd7, 4'd1, 4'd2, 15'd0}, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0);
        checkCycle();
        applyReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'd0, 1'b0);
        checkOutput("reset_r7", rf[7], 32'hA5A5_A5A5);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) != 0) op = LEGAL_OPS[$urandom_range(0, 13)];
            else op = 5'($urandom_range(0, 31));
            applyStimulus(1'($urandom_range(0, 1)), {op, 27'($urandom)}, $urandom_range(0, 4) == 0);
        end
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 16; i++) checkOutput($sformatf("rf%0d", i), rf[i], expRf[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
